riscv_ifetch: RTL and testbench
===============================

// Module: riscv_ifetch
// PURPOSE
//  Instruction-fetch front end; the requester side of riscv_imem. Holds the PC and drives the
//  word index into the async-read IMEM. Captures {pc, inst} into a 2-entry fetch buffer and
//  hands them to decode over a valid/ready handshake. Handles redirects (branch/jump/trap)
//  with a buffer flush. Sits between riscv_imem and the decode stage.
// PARAMETERS
//  XLEN           32              data/PC width (default from `XLEN)
//  IMEM_ADDR_BIT  `IMEM_ADDR_BIT  IMEM byte-address width; IMEM holds 2**(IMEM_ADDR_BIT-2) words
//  RESET_PC       32'h0000_0000   PC loaded on reset
// PORTS
//  i_clk             in   1                 clock, rising edge
//  i_rstn            in   1                 reset, synchronous, active-low
//  o_imem_addr       out  IMEM_ADDR_BIT-2   word index to riscv_imem = pc[IMEM_ADDR_BIT-1:2]
//  i_imem_data       in   XLEN              instruction word from riscv_imem, same cycle
//  i_redirect_valid  in   1                 one-cycle request to restart fetch at i_redirect_pc
//  i_redirect_pc     in   XLEN              redirect target byte address
//  o_valid           out  1                 fetch buffer head valid
//  i_ready           in   1                 decode accepts head when o_valid & i_ready
//  o_inst            out  XLEN              head instruction; `RV_NOP when o_valid=0
//  o_pc              out  XLEN              head PC; 0 when o_valid=0
//  o_misalign        out  1                 one-cycle pulse: redirect target had pc[1:0]!=0
// BEHAVIOUR
//  Reset (posedge i_clk with i_rstn=0): pc<=RESET_PC, buffer emptied, o_valid=0, o_inst=`RV_NOP,
//   o_pc=0, o_misalign=0. No fetch is pushed in a cycle where i_rstn=0.
//  o_imem_addr is combinational from the pc register. IMEM read is zero-latency, so
//   i_imem_data is valid in the same cycle.
//  Fetch condition per cycle: fire = i_rstn & ~i_redirect_valid & (count<2 | pop).
//   pop = o_valid & i_ready. On fire: push {pc, i_imem_data}, pc<=pc+4.
//   Otherwise pc holds.
//  Buffer: 2-entry FIFO with registered head. Simultaneous push+pop at count=2 is legal and
//   keeps count=2. Push+pop at count=1 keeps count=1. Order is strictly FIFO.
//  Steady state with i_ready=1: one instruction per cycle. After reset release the first
//   o_valid is 1 cycle after the first cycle with i_rstn=1.
//  Redirect (i_redirect_valid=1 in cycle N):
//   - flush the buffer at the N edge; a pop in cycle N still completes for decode,
//     and no push occurs in N.
//   - pc<={i_redirect_pc[XLEN-1:2],2'b00}.
//   - target fetched in N+1; o_valid with o_pc=target in N+2.
//   - redirect overrides push; stall has no effect on redirect.
//  Misaligned target: low bits forced to 00; o_misalign=1 in cycle N+1 only.
//   Redirects in consecutive cycles: the last one wins, and each misaligned one pulses.
//  pc wraps modulo 2**XLEN (pc+4 truncated). IMEM index uses only pc[IMEM_ADDR_BIT-1:2],
//   so addresses alias modulo IMEM size. No range error is raised.
//  Stall: i_ready=0 with o_valid=1 holds o_inst/o_pc stable. The buffer fills to 2, then
//   pc holds. o_imem_addr stays stable while stalled.
//  Reset mid-operation (i_rstn=0 while buffer non-empty or redirect pending): reset wins;
//   all state returns to reset values at that edge.
// STRUCTURE
//  Shared config header riscv_configs.v: `XLEN, `IMEM_ADDR_BIT, `RV_NOP (32'h0000_0013),
//   `RESET_PC default.
//  One sub-module, riscv_fetch_fifo: 2-entry {pc, inst} FIFO with push/pop/flush and a count
//   output. The PC register and fire logic stay in riscv_ifetch.
// TESTING
//  - Reset, IMEM preloaded words 0..7, i_ready=1 -> o_pc=0,4,8,... on consecutive cycles;
//    o_inst matches IMEM; o_valid rises 1 cycle after i_rstn=1.
//  - i_ready=0 for 5 cycles at pc=0x10 -> head stays 0x10 with the second entry 0x14 held;
//    pc holds at 0x18 and o_imem_addr=6; release -> 0x10,0x14,0x18 with no gap or duplicate.
//  - Redirect to 0x40 in cycle N with a full buffer -> entries dropped; o_valid=0 in N+1;
//    o_pc=0x40 in N+2, then 0x44.
//  - Redirect to 0x42 -> o_misalign=1 for exactly one cycle, then o_pc=0x40.
//  - Redirect in N and N+1 (0x80 then 0xC0) -> 0x80 is never presented; first valid o_pc=0xC0.
//  - With IMEM_ADDR_BIT=10, fetch from 0x3FC -> next o_pc=0x400 and o_imem_addr=0, i.e. the
//    same instruction as pc 0x000.
//  - Assert i_rstn=0 mid-stall -> o_valid=0 and o_inst=`RV_NOP next cycle; restart from
//    RESET_PC.

Source files
------------

// File: rtl/riscv_ifetch_pkg.sv
// rtl/riscv_ifetch_pkg.sv - shared fetch configuration macros, constants and helpers
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 10
`endif
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif

package riscv_ifetch_pkg;

  localparam logic [31:0] RV_NOP_INST = `RV_NOP;
  localparam int          FETCH_DEPTH = 2;

  typedef logic [1:0] fifo_count_t;

  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return |lo_bits;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - 2-entry {pc, inst} fetch FIFO with registered head and flush
module riscv_fetch_fifo
  import riscv_ifetch_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_pc,
  input  logic [XLEN-1:0] i_push_inst,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [1:0]      o_count,
  output logic [XLEN-1:0] o_head_pc,
  output logic [XLEN-1:0] o_head_inst
);

  fifo_count_t     count_q, count_d;
  logic [XLEN-1:0] pc0_q, pc0_d, inst0_q, inst0_d;
  logic [XLEN-1:0] pc1_q, pc1_d, inst1_q, inst1_d;
  logic [1:0]      wr_idx;

  // Slot 0 is always the head; a pop shifts slot 1 down before the push lands.
  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;
    wr_idx  = count_q - {1'b0, i_pop};
    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      if (i_pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (i_push) begin
        if (wr_idx == 2'd0) begin
          pc0_d   = i_push_pc;
          inst0_d = i_push_inst;
        end else begin
          pc1_d   = i_push_pc;
          inst1_d = i_push_inst;
        end
      end
      count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count_q <= 2'd0;
      pc0_q   <= '0;
      inst0_q <= '0;
      pc1_q   <= '0;
      inst1_q <= '0;
    end else begin
      count_q <= count_d;
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
    end
  end

  assign o_count     = count_q;
  assign o_head_pc   = pc0_q;
  assign o_head_inst = inst0_q;

endmodule

// File: rtl/riscv_ifetch.sv
// rtl/riscv_ifetch.sv - instruction fetch front end: PC, IMEM index, fetch buffer, redirects
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter int              XLEN          = `XLEN,
  parameter int              IMEM_ADDR_BIT = `IMEM_ADDR_BIT,
  parameter logic [XLEN-1:0] RESET_PC      = `RESET_PC
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
  input  logic [XLEN-1:0]          i_imem_data,
  input  logic                     i_redirect_valid,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_inst,
  output logic [XLEN-1:0]          o_pc,
  output logic                     o_misalign
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [1:0]      count;
  logic [XLEN-1:0] head_pc, head_inst;
  logic            pop, fire;

  assign o_valid     = (count != 2'd0);
  assign pop         = o_valid & i_ready;
  assign fire        = i_rstn & ~i_redirect_valid & ((count < 2'd2) | pop);
  assign o_imem_addr = pc_q[IMEM_ADDR_BIT-1:2];

  // Redirect beats any fetch; pc simply wraps on overflow.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (i_redirect_valid) begin
      pc_d       = {i_redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = is_misaligned(i_redirect_pc[1:0]);
    end else if (fire) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  riscv_fetch_fifo #(.XLEN(XLEN)) u_fifo (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (fire),
    .i_push_pc   (pc_q),
    .i_push_inst (i_imem_data),
    .i_pop       (pop),
    .i_flush     (i_redirect_valid),
    .o_count     (count),
    .o_head_pc   (head_pc),
    .o_head_inst (head_inst)
  );

  assign o_inst     = o_valid ? head_inst : XLEN'(RV_NOP_INST);
  assign o_pc       = o_valid ? head_pc : '0;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_riscv_ifetch.sv
// tb/tb_riscv_ifetch.sv - directed self-checking bench for riscv_ifetch
module tb_riscv_ifetch;

  logic        clk;
  logic        rstn;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        misalign;

  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_ifetch #(.XLEN(32), .IMEM_ADDR_BIT(10), .RESET_PC(32'h0)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_valid          (valid),
    .i_ready          (ready),
    .o_inst           (inst),
    .o_pc             (pc),
    .o_misalign       (misalign)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(i);
    rstn = 1'b0;
    ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_inst", inst, NOP);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);

    // first cycle out of reset: nothing presented yet
    rstn = 1'b1;
    check_eq("rel_valid0", 32'(valid), 32'd0);
    tick();
    check_eq("rel_valid1", 32'(valid), 32'd1);
    check_eq("seq_pc0", pc, 32'h0);
    check_eq("seq_inst0", inst, word(0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("seq_pc", pc, 32'(4 * k));
      check_eq("seq_inst", inst, word(k));
    end

    // stall with head 0x10
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_valid", 32'(valid), 32'd1);
      check_eq("stall_pc", pc, 32'h10);
      check_eq("stall_inst", inst, word(4));
      check_eq("stall_addr", 32'(imem_addr), 32'd6);
    end
    ready = 1'b1;
    check_eq("release_pc10", pc, 32'h10);
    tick();
    check_eq("release_pc14", pc, 32'h14);
    check_eq("release_inst14", inst, word(5));
    tick();
    check_eq("release_pc18", pc, 32'h18);
    tick();
    check_eq("release_pc1c", pc, 32'h1C);

    // fill buffer, then redirect to 0x40 while stalled
    ready = 1'b0;
    tick();
    check_eq("full_pc", pc, 32'h1C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    ready = 1'b1;
    check_eq("redir_n1_valid", 32'(valid), 32'd0);
    check_eq("redir_n1_misalign", 32'(misalign), 32'd0);
    check_eq("redir_n1_addr", 32'(imem_addr), 32'h10);
    tick();
    check_eq("redir_n2_valid", 32'(valid), 32'd1);
    check_eq("redir_n2_pc", pc, 32'h40);
    check_eq("redir_n2_inst", inst, word(16));
    tick();
    check_eq("redir_n3_pc", pc, 32'h44);

    // misaligned target
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_n1_pulse", 32'(misalign), 32'd1);
    check_eq("mis_n1_valid", 32'(valid), 32'd0);
    tick();
    check_eq("mis_n2_pulse", 32'(misalign), 32'd0);
    check_eq("mis_n2_pc", pc, 32'h40);

    // back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_pc = 32'hC0;
    check_eq("b2b_n1_valid", 32'(valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("b2b_n2_valid", 32'(valid), 32'd0);
    tick();
    check_eq("b2b_valid", 32'(valid), 32'd1);
    check_eq("b2b_pc", pc, 32'hC0);
    tick();
    check_eq("b2b_pc_next", pc, 32'hC4);

    // IMEM index aliasing past the top of a 1 KiB memory
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_addr_top", 32'(imem_addr), 32'hFF);
    tick();
    check_eq("wrap_pc3fc", pc, 32'h3FC);
    check_eq("wrap_inst3fc", inst, word(255));
    check_eq("wrap_addr0", 32'(imem_addr), 32'd0);
    tick();
    check_eq("wrap_pc400", pc, 32'h400);
    check_eq("wrap_inst400", inst, word(0));

    // reset in the middle of a stall
    ready = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_valid", 32'(valid), 32'd1);
    rstn = 1'b0;
    tick();
    check_eq("midrst_valid", 32'(valid), 32'd0);
    check_eq("midrst_inst", inst, NOP);
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_addr", 32'(imem_addr), 32'd0);
    rstn = 1'b1;
    tick();
    check_eq("restart_valid", 32'(valid), 32'd1);
    check_eq("restart_pc", pc, 32'h0);
    check_eq("restart_inst", inst, word(0));
    ready = 1'b1;
    tick();
    check_eq("restart_pc4", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
